// File: rtl/banked_ram_ctrl_if.sv
// Request/response bus of the banked RAM controller.
// The master drives requests; the slave (the controller) returns ready and responses.
interface banked_ram_ctrl_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/banked_ram_ctrl.sv
// Banked single-port RAM controller. The high address bits pick a bank; only
// the first MAP_BANKS banks hold memory, the rest answer with an error.
// After reset or clr, every populated row is zeroed before requests are taken.
module banked_ram_ctrl #(
   parameter int DATA_W    = 8,
   parameter int BANK_AW   = 9,
   parameter int BANKS     = 4,
   parameter int MAP_BANKS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              init_done,
   banked_ram_ctrl_if.slave  bus
);
   localparam int BANK_W = $clog2(BANKS);
   localparam int ADDR_W = BANK_AW + BANK_W;
   localparam int BE_W   = DATA_W / 8;
   localparam int DEPTH  = 1 << BANK_AW;

   localparam logic [BANK_AW-1:0] CNT_LAST = '1;
   localparam logic [BANK_W:0]    MAP_L    = (BANK_W+1)'(MAP_BANKS);
   localparam logic [BANKS-1:0]   POP_MASK = BANKS'((64'd1 << MAP_BANKS) - 64'd1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [BANK_AW-1:0]   r_cnt;
   logic [BANK_AW-1:0]   w_cnt_next;

   logic                 w_ready;
   logic                 w_accept;
   logic [BANK_W-1:0]    w_bank;
   logic [BANK_AW-1:0]   w_row;
   logic                 w_mapped;
   logic [BANKS-1:0]     w_bank_en;

   logic [BANK_AW-1:0]   w_mem_row;
   logic                 w_mem_we;
   logic [DATA_W-1:0]    w_mem_wdata;
   logic [BE_W-1:0]      w_mem_be;
   logic [BANKS-1:0][DATA_W-1:0] w_bank_rdata;

   logic                 r_rsp_valid;
   logic                 r_rsp_rd;
   logic                 r_rsp_err;
   logic [BANK_W-1:0]    r_rsp_bank;

   // Handshake: ready depends only on registered state and clr. Reset blocks
   // acceptance internally so nothing is written or answered while it is high.
   assign w_ready  = (r_state == ST_RUN) && !clr;
   assign w_accept = bus.req_valid && w_ready && !rst;
   assign w_bank   = bus.req_addr[ADDR_W-1:BANK_AW];
   assign w_row    = bus.req_addr[BANK_AW-1:0];
   assign w_mapped = ({1'b0, w_bank} < MAP_L);

   // State and init-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state: INIT walks every row once, RUN falls back to INIT on clr.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_INIT: begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
            end
         end
         ST_RUN: begin
            if (clr) begin
               w_state_next = ST_INIT;
               w_cnt_next   = '0;
            end
         end
         default: begin
            w_state_next = ST_INIT;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Bank enables: all populated banks while zeroing, one-hot on an accepted
   // request to a populated bank otherwise.
   always_comb begin
      w_bank_en = '0;
      if (r_state == ST_INIT)
         w_bank_en = POP_MASK;
      else if (w_accept && w_mapped)
         w_bank_en[w_bank] = 1'b1;
   end

   // Shared memory-port signals: the init sequence overrides the request bus.
   always_comb begin
      w_mem_row   = w_row;
      w_mem_we    = w_accept && bus.req_we;
      w_mem_wdata = bus.req_wdata;
      w_mem_be    = bus.req_be;
      if (r_state == ST_INIT) begin
         w_mem_row   = r_cnt;
         w_mem_we    = 1'b1;
         w_mem_wdata = '0;
         w_mem_be    = '1;
      end
   end

   // One byte-wide RAM per lane per populated bank, so byte enables map onto
   // independent write enables. Unpopulated slots read as zero.
   genvar gi, gj;
   generate
      for (gi = 0; gi < BANKS; gi++) begin : g_bank
         if (gi < MAP_BANKS) begin : g_pop
            for (gj = 0; gj < BE_W; gj++) begin : g_lane
               logic [7:0] r_mem [DEPTH];
               logic [7:0] r_rd;

               // Byte-lane RAM with registered read (old data on a write).
               always_ff @(posedge clk) begin
                  if (w_bank_en[gi]) begin
                     if (w_mem_we && w_mem_be[gj])
                        r_mem[w_mem_row] <= w_mem_wdata[gj*8 +: 8];
                     r_rd <= r_mem[w_mem_row];
                  end
               end

               assign w_bank_rdata[gi][gj*8 +: 8] = r_rd;
            end
         end else begin : g_unpop
            assign w_bank_rdata[gi] = '0;
         end
      end
   endgenerate

   // Response pipeline: one pulse per accepted request, independent of state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rd    <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_bank  <= '0;
      end else begin
         r_rsp_valid <= w_accept;
         if (w_accept) begin
            r_rsp_rd   <= !bus.req_we;
            r_rsp_err  <= !w_mapped;
            r_rsp_bank <= w_bank;
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_valid && r_rsp_err;
   assign bus.rsp_rdata = (r_rsp_valid && r_rsp_rd && !r_rsp_err) ?
                          w_bank_rdata[r_rsp_bank] : '0;
   assign init_done     = (r_state == ST_RUN);
endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Directed bench for banked_ram_ctrl: an 8-bit instance for init, decode,
// unmapped-bank, clr and reset tests, and a 32-bit instance for byte enables.
module tb_banked_ram_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic clr8, clr32;
   logic done8, done32;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       tag;
   } exp_t;

   exp_t q8[$];
   exp_t q32[$];

   always #5 clk = ~clk;

   banked_ram_ctrl_if #(.ADDR_W(11), .DATA_W(8))  if8 ();
   banked_ram_ctrl_if #(.ADDR_W(11), .DATA_W(32)) if32 ();

   banked_ram_ctrl #(.DATA_W(8), .BANK_AW(9), .BANKS(4), .MAP_BANKS(3)) dut (
      .clk(clk), .rst(rst), .clr(clr8), .init_done(done8), .bus(if8.slave)
   );

   banked_ram_ctrl #(.DATA_W(32), .BANK_AW(9), .BANKS(4), .MAP_BANKS(3)) dut32 (
      .clk(clk), .rst(rst), .clr(clr32), .init_done(done32), .bus(if32.slave)
   );

   task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic idle();
      if8.req_valid  = 1'b0; if8.req_we  = 1'b0; if8.req_addr  = '0;
      if8.req_wdata  = '0;   if8.req_be  = '0;
      if32.req_valid = 1'b0; if32.req_we = 1'b0; if32.req_addr = '0;
      if32.req_wdata = '0;   if32.req_be = '0;
   endtask

   // Present one request for one cycle; expectation is queued once accepted.
   task automatic req(input bit w32, input bit we, input logic [10:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] erd, input logic eerr, input string tag);
      logic rdy;
      if (w32) begin
         if32.req_valid = 1'b1; if32.req_we = we; if32.req_addr = addr;
         if32.req_wdata = wd;   if32.req_be = be;
         if8.req_valid  = 1'b0;
      end else begin
         if8.req_valid = 1'b1; if8.req_we = we; if8.req_addr = addr;
         if8.req_wdata = wd[7:0]; if8.req_be = be[0];
         if32.req_valid = 1'b0;
      end
      @(negedge clk);
      rdy = w32 ? if32.req_ready : if8.req_ready;
      check({31'd0, rdy}, 32'd1, {tag, "_ready"});
      if (rdy === 1'b1) begin
         if (w32) q32.push_back('{erd, eerr, tag});
         else     q8.push_back('{erd, eerr, tag});
      end
      @(posedge clk); #1;
   endtask

   // Count cycles with req_ready low on the 8-bit instance, bounded.
   task automatic count_init(input string tag);
      int n = 0;
      @(negedge clk);
      while (if8.req_ready !== 1'b1 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check(n, 512, tag);
   endtask

   // Scoreboard: every response pops and compares one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (if8.rsp_valid === 1'b1) begin
         check({31'd0, q8.size() != 0}, 32'd1, "rsp8_expected");
         if (q8.size() != 0) begin
            e = q8.pop_front();
            check({24'd0, if8.rsp_rdata}, e.rdata, {e.tag, "_rdata"});
            check({31'd0, if8.rsp_err}, {31'd0, e.err}, {e.tag, "_err"});
         end
      end
      if (if32.rsp_valid === 1'b1) begin
         check({31'd0, q32.size() != 0}, 32'd1, "rsp32_expected");
         if (q32.size() != 0) begin
            e = q32.pop_front();
            check(if32.rsp_rdata, e.rdata, {e.tag, "_rdata"});
            check({31'd0, if32.rsp_err}, {31'd0, e.err}, {e.tag, "_err"});
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; clr8 = 1'b0; clr32 = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({31'd0, if8.req_ready}, 32'd0, "rst_ready");
      check({31'd0, if8.rsp_valid}, 32'd0, "rst_rsp_valid");
      check({24'd0, if8.rsp_rdata}, 32'd0, "rst_rsp_rdata");
      check({31'd0, if8.rsp_err},   32'd0, "rst_rsp_err");
      check({31'd0, done8},         32'd0, "rst_init_done");
      @(posedge clk); #1;
      rst = 1'b0;

      // Init length, then zeroed memory.
      count_init("init_len");
      check({31'd0, done8}, 32'd1, "init_done_high");
      @(posedge clk); #1;
      req(0, 0, 11'h000, 0, 0, 32'h00, 0, "init_rd0");

      // Bank decode, back-to-back writes then reads.
      req(0, 1, 11'h000, 32'hA5, 1, 32'h0, 0, "wr_b0");
      req(0, 1, 11'h200, 32'h3C, 1, 32'h0, 0, "wr_b1");
      req(0, 1, 11'h5FF, 32'h81, 1, 32'h0, 0, "wr_b2");
      req(0, 0, 11'h000, 0, 0, 32'hA5, 0, "rd_b0");
      req(0, 0, 11'h200, 0, 0, 32'h3C, 0, "rd_b1");
      req(0, 0, 11'h5FF, 0, 0, 32'h81, 0, "rd_b2");

      // Unpopulated bank 3 errors; bank 2 unaffected.
      req(0, 1, 11'h600, 32'hFF, 1, 32'h0, 1, "wr_unmap");
      req(0, 0, 11'h600, 0, 0, 32'h0, 1, "rd_unmap");
      req(0, 0, 11'h400, 0, 0, 32'h0, 0, "rd_b2_row0");
      req(0, 1, 11'h011, 32'h5A, 0, 32'h0, 0, "wr_be0");
      req(0, 0, 11'h011, 0, 0, 32'h0, 0, "rd_be0");
      idle();

      // Byte enables with read-after-write on the 32-bit instance.
      req(1, 1, 11'h005, 32'h11223344, 4'hF, 32'h0, 0, "w32_full");
      req(1, 1, 11'h005, 32'hAABBCCDD, 4'b0101, 32'h0, 0, "w32_part");
      req(1, 0, 11'h005, 0, 0, 32'h11BB33DD, 0, "r32_merge");
      req(1, 0, 11'h605, 0, 0, 32'h0, 1, "r32_unmap");
      idle();
      repeat (2) @(posedge clk); #1;

      // clr collision: preceding write still answered, colliding read is not.
      req(0, 1, 11'h010, 32'h77, 1, 32'h0, 0, "wr_pre_clr");
      if8.req_valid = 1'b1; if8.req_we = 1'b0; if8.req_addr = 11'h010;
      clr8 = 1'b1;
      @(negedge clk);
      check({31'd0, if8.req_ready}, 32'd0, "clr_ready");
      @(posedge clk); #1;
      clr8 = 1'b0;
      idle();
      count_init("clr_init_len");
      @(posedge clk); #1;
      req(0, 0, 11'h010, 0, 0, 32'h00, 0, "rd_after_clr");
      idle();

      // Reset in the middle of INIT restarts the full sequence.
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (200) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check({31'd0, if8.rsp_valid}, 32'd0, "midinit_rsp_valid");
      count_init("midinit_len");

      repeat (3) @(posedge clk); #1;
      check(q8.size(), 0, "q8_drained");
      check(q32.size(), 0, "q32_drained");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/banked_ram_ctrl.md
# banked_ram_ctrl

Parametrised banked single-port RAM with a valid/ready request port. Replaces fixed-size discrete RAM assemblies built from smaller chips plus a chip-select decoder. Address high bits select one of BANKS internal banks. Only the first MAP_BANKS banks are populated; accesses to the others are flagged as errors. After reset or a clear request, a hardware init sequence zeroes all populated memory before requests are accepted.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- BANK_AW, 9: address bits per bank; bank depth DEPTH = 2^BANK_AW.
- BANKS, 4: number of bank slots; power of two, ≥2. Localparam ADDR_W = BANK_AW + log2(BANKS).
- MAP_BANKS, 3: populated banks, indices 0..MAP_BANKS-1; 1 ≤ MAP_BANKS ≤ BANKS.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  single-cycle pulse that re-enters INIT and zeroes all memory; ignored outside RUN.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address; [ADDR_W-1:BANK_AW] = bank index, [BANK_AW-1:0] = row.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored for reads.
- rsp_valid  out  1  one-cycle response pulse, exactly one per accepted request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  accepted address targets an unpopulated bank.
- init_done  out  1  high while in RUN.

## Operation
- States:
  - INIT: counter cnt walks 0..DEPTH-1. Each cycle writes 0 at row cnt in every populated bank.
  - RUN: serves requests.
- Transitions:
  - rst → INIT with cnt=0, checked every edge and dominant over everything else.
  - INIT with cnt==DEPTH-1 → RUN on that edge; the final row is written on the same edge.
  - RUN with clr → INIT with cnt=0.
- req_ready = (state==RUN) && !clr. This is combinational from registered state and clr only, not from req_valid.
- Accepted write to a populated bank: each byte i with req_be[i]=1 is updated; other bytes are unchanged. req_be=0 is legal and produces no change but still gets a response.
- Accepted write to an unpopulated bank: dropped; response has rsp_err=1.
- Accepted read: returns the stored word; unpopulated bank returns rsp_rdata=0, rsp_err=1.
- Bank decode is one-hot internally; at most one bank is enabled per cycle in RUN, and all populated banks are enabled in INIT.
- There is no response backpressure; the consumer must sample every rsp_valid.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - Memory contents are undefined until INIT completes.

## Timing
- rst deasserted before edge E0: INIT writes occur on E0..E(DEPTH-1). req_ready and init_done are high starting the cycle after E(DEPTH-1).
- A request accepted at edge N produces rsp_valid/rsp_rdata/rsp_err registered at N and visible in cycle N+1.
- Throughput: one request per cycle, sustained.
- Read-after-write to the same address on consecutive cycles returns the new data; the write commits at edge N and the read samples the array at edge N+1.
- Reading in the same cycle as a write is impossible (single request per cycle).
- clr in the same cycle as req_valid: clr wins and the request is not accepted.
- A response for a request accepted at the edge before clr is still delivered; rsp_valid does not depend on state.
- rst asserted mid-INIT or mid-RUN: the next edge forces INIT with cnt=0 and rsp_valid=0. Any pending response is discarded.
- rst and clr together: rst behaviour applies.

## Test plan
- Init timing (DEPTH=512): rst high 3 cycles, then low → req_ready=0 for exactly 512 cycles, then 1; a read of addr 0x000 returns rsp_rdata=0x00, rsp_err=0 one cycle after acceptance.
- Bank decode and back-to-back access: write 0xA5 to 0x000, 0x3C to 0x200, 0x81 to 0x5FF on consecutive cycles, then read them back-to-back → 0xA5, 0x3C, 0x81, one rsp_valid per cycle, rsp_err=0.
- Unmapped bank: write 0xFF to 0x600, then read 0x600 → both responses have rsp_err=1, read rsp_rdata=0; a read of 0x400 is unaffected.
- Byte enables and read-after-write (DATA_W=32): write 0x11223344 be=4'hF to row 5, next cycle write 0xAABBCCDD be=4'b0101, next cycle read → 0x11BB33DD.
- clr collision: write 0x77 to 0x010; assert clr with req_valid high → request not accepted, req_ready low for 512 cycles; after init, a read of 0x010 returns 0x00.
- Reset mid-INIT: assert rst at cnt=200 → INIT restarts, and req_ready rises exactly 512 cycles after rst deasserts.
